// File: rtl/npu_fc2_argmax_if.sv
// Handshake bundle between the FC2 score stream, the argmax stage and the
// result consumer. The master side is the environment (FC2 producer plus the
// host/display consumer); the slave side is the argmax stage itself.
interface npu_fc2_argmax_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 5
);
    logic                  frame_start_p;
    logic [DATA_WIDTH-1:0] fc2_layer_output_data;
    logic                  fc2_layer_output_valid_p;
    logic [IDX_WIDTH-1:0]  class_idx;
    logic [DATA_WIDTH-1:0] class_score;
    logic [7:0]            class_margin;
    logic                  class_valid;
    logic                  class_ack_p;
    logic                  busy;
    logic                  seq_err;

    modport master (
        output frame_start_p,
        output fc2_layer_output_data,
        output fc2_layer_output_valid_p,
        output class_ack_p,
        input  class_idx,
        input  class_score,
        input  class_margin,
        input  class_valid,
        input  busy,
        input  seq_err
    );

    modport slave (
        input  frame_start_p,
        input  fc2_layer_output_data,
        input  fc2_layer_output_valid_p,
        input  class_ack_p,
        output class_idx,
        output class_score,
        output class_margin,
        output class_valid,
        output busy,
        output seq_err
    );
endinterface

// File: rtl/npu_fc2_argmax.sv
// Argmax classifier behind the FC2 layer: tracks best score, its index and the
// runner-up while the class scores stream in, then holds the winning index,
// score and best-minus-runner-up margin until the consumer acknowledges.
module npu_fc2_argmax #(
    parameter int NUM_CLASSES = 24,
    parameter int DATA_WIDTH  = 8,
    parameter int IDX_WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    npu_fc2_argmax_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t state;
    state_t next_state;

    logic [IDX_WIDTH-1:0]         cnt;
    logic signed [DATA_WIDTH-1:0] best;
    logic signed [DATA_WIDTH-1:0] second;
    logic [IDX_WIDTH-1:0]         best_idx;

    logic                         start_acc;
    logic                         sample_acc;
    logic                         last_sample;
    logic                         protocol_err;
    logic signed [DATA_WIDTH-1:0] d;
    logic [IDX_WIDTH-1:0]         base_cnt;
    logic signed [DATA_WIDTH-1:0] base_best;
    logic signed [DATA_WIDTH-1:0] base_second;
    logic [IDX_WIDTH-1:0]         base_idx;
    logic signed [DATA_WIDTH-1:0] upd_best;
    logic signed [DATA_WIDTH-1:0] upd_second;
    logic [IDX_WIDTH-1:0]         upd_idx;
    logic [DATA_WIDTH:0]          margin_wide;

    // Decide which strobes are honoured this cycle; a start accepted together
    // with a sample makes the sample index 0 of the new frame, so the compare
    // runs against the freshly-armed values rather than the stale registers.
    always_comb begin
        start_acc    = bus.frame_start_p &&
                       ((state == IDLE) || (state == COLLECT) ||
                        ((state == HOLD) && bus.class_ack_p));
        sample_acc   = bus.fc2_layer_output_valid_p && (start_acc || (state == COLLECT));
        protocol_err = bus.fc2_layer_output_valid_p && !sample_acc;
        d            = bus.fc2_layer_output_data;

        base_cnt     = start_acc ? '0        : cnt;
        base_best    = start_acc ? SCORE_MIN : best;
        base_second  = start_acc ? SCORE_MIN : second;
        base_idx     = start_acc ? '0        : best_idx;

        upd_best     = base_best;
        upd_second   = base_second;
        upd_idx      = base_idx;
        if (d > base_best) begin
            upd_second = base_best;
            upd_best   = d;
            upd_idx    = base_cnt;
        end else if (d > base_second) begin
            upd_second = d;
        end

        last_sample  = sample_acc && (base_cnt == LAST_IDX);
        margin_wide  = {upd_best[DATA_WIDTH-1], upd_best} -
                       {upd_second[DATA_WIDTH-1], upd_second};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a start always (re)enters COLLECT, the last sample
    // moves to HOLD, and an ack without a start returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (last_sample) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.class_ack_p) begin
                    next_state = start_acc ? COLLECT : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        bus.class_valid = (state == HOLD);
        bus.busy        = (state != IDLE);
    end

    // Working registers: arm on an accepted start, fold in accepted samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
        end else if (sample_acc) begin
            cnt      <= base_cnt + IDX_WIDTH'(1);
            best     <= upd_best;
            second   <= upd_second;
            best_idx <= upd_idx;
        end else if (start_acc) begin
            cnt      <= '0;
            best     <= SCORE_MIN;
            second   <= SCORE_MIN;
            best_idx <= '0;
        end
    end

    // Result registers load once per completed frame and hold until the next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.class_idx    <= '0;
            bus.class_score  <= '0;
            bus.class_margin <= '0;
        end else if (last_sample) begin
            bus.class_idx    <= upd_idx;
            bus.class_score  <= upd_best;
            bus.class_margin <= 8'(margin_wide);
        end
    end

    // Sticky flag for samples that arrive when no frame is being collected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.seq_err <= 1'b0;
        end else if (protocol_err) begin
            bus.seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_npu_fc2_argmax.sv
// Directed bench for npu_fc2_argmax: hand-computed frames, HOLD corner cases,
// abort, sticky protocol error and asynchronous reset.
module tb_npu_fc2_argmax;

    localparam int NUM_CLASSES = 24;
    localparam int DATA_WIDTH  = 8;
    localparam int IDX_WIDTH   = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] frame [NUM_CLASSES];

    npu_fc2_argmax_if #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

    npu_fc2_argmax #(
        .NUM_CLASSES(NUM_CLASSES),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, let the edge happen, sample #1 after it
    task automatic apply_stimulus(input logic start, input logic valid,
                                  input logic [7:0] data, input logic ack);
        bus.frame_start_p            = start;
        bus.fc2_layer_output_valid_p = valid;
        bus.fc2_layer_output_data    = data;
        bus.class_ack_p              = ack;
        @(posedge clk);
        #1;
        bus.frame_start_p            = 1'b0;
        bus.fc2_layer_output_valid_p = 1'b0;
        bus.fc2_layer_output_data    = 8'h00;
        bus.class_ack_p              = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] idx,
                                input logic [31:0] score, input logic [31:0] margin);
        check_output({tag, "_valid"},  32'(bus.class_valid),  32'd1);
        check_output({tag, "_idx"},    32'(bus.class_idx),    idx);
        check_output({tag, "_score"},  32'(bus.class_score),  score);
        check_output({tag, "_margin"}, 32'(bus.class_margin), margin);
    endtask

    // Start (separately or with sample 0), then stream the whole frame back to back
    task automatic send_frame(input string tag, input bit start_with_first);
        int first;
        first = 0;
        if (start_with_first) begin
            apply_stimulus(1'b1, 1'b1, frame[0], 1'b0);
            first = 1;
        end else begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        end
        check_output({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        for (int i = first; i < NUM_CLASSES; i++) begin
            apply_stimulus(1'b0, 1'b1, frame[i], 1'b0);
            if (i == NUM_CLASSES - 2) begin
                check_output({tag, "_no_early_valid"}, 32'(bus.class_valid), 32'd0);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NUM_CLASSES; i++) frame[i] = 8'(i - 10);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < NUM_CLASSES; i++) frame[i] = v;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.frame_start_p            = 1'b0;
        bus.fc2_layer_output_valid_p = 1'b0;
        bus.fc2_layer_output_data    = 8'h00;
        bus.class_ack_p              = 1'b0;
        rst = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy",   32'(bus.busy),        32'd0);
        check_output("rst_valid",  32'(bus.class_valid), 32'd0);
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("rel_idx",    32'(bus.class_idx),    32'd0);
        check_output("rel_score",  32'(bus.class_score),  32'd0);
        check_output("rel_margin", 32'(bus.class_margin), 32'd0);
        check_output("rel_valid",  32'(bus.class_valid),  32'd0);
        check_output("rel_busy",   32'(bus.busy),         32'd0);
        check_output("rel_seqerr", 32'(bus.seq_err),      32'd0);

        // Mid-frame winner 100 at index 7, runner-up 90 at index 15
        $display("[TB] basic frame");
        fill_ramp();
        frame[7]  = 8'd100;
        frame[15] = 8'd90;
        send_frame("basic", 1'b0);
        check_result("basic", 32'd7, 32'h64, 32'd10);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        end
        check_result("basic_held", 32'd7, 32'h64, 32'd10);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        check_output("basic_ack_valid", 32'(bus.class_valid), 32'd0);
        check_output("basic_ack_busy",  32'(bus.busy),        32'd0);
        check_output("basic_ack_keep",  32'(bus.class_idx),   32'd7);

        // All scores at the minimum: index 0 wins with zero margin
        fill_const(8'h80);
        send_frame("allmin", 1'b0);
        check_result("allmin", 32'd0, 32'h80, 32'd0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Tie for the maximum keeps the lower index
        fill_const(8'h00);
        frame[3]  = 8'd50;
        frame[20] = 8'd50;
        send_frame("tie", 1'b0);
        check_result("tie", 32'd3, 32'h32, 32'd0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Last index wins with the full 255 margin
        fill_const(8'h80);
        frame[23] = 8'h7f;
        send_frame("lastidx", 1'b0);
        check_result("lastidx", 32'd23, 32'h7f, 32'd255);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Start together with sample 0 (minimum-length frame)
        fill_const(8'h00);
        frame[0] = 8'h7f;
        send_frame("startfirst", 1'b1);
        check_result("startfirst", 32'd0, 32'h7f, 32'd127);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Abort: partial frame of large scores, then a fresh full frame
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 8'd120, 1'b0);
        end
        fill_ramp();
        frame[12] = 8'd60;
        send_frame("abort", 1'b0);
        check_result("abort", 32'd12, 32'h3c, 32'd47);
        check_output("abort_seqerr", 32'(bus.seq_err), 32'd0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Stray sample in IDLE sets the sticky error and produces nothing
        apply_stimulus(1'b0, 1'b1, 8'h7f, 1'b0);
        check_output("idle_seqerr", 32'(bus.seq_err),     32'd1);
        check_output("idle_valid",  32'(bus.class_valid), 32'd0);
        check_output("idle_busy",   32'(bus.busy),        32'd0);

        // HOLD corner cases: stray sample, ignored start, ack with start
        fill_ramp();
        frame[5] = 8'd77;
        send_frame("hold", 1'b0);
        check_result("hold", 32'd5, 32'h4d, 32'd64);
        apply_stimulus(1'b0, 1'b1, 8'h7f, 1'b0);
        check_result("hold_stray", 32'd5, 32'h4d, 32'd64);
        check_output("hold_seqerr", 32'(bus.seq_err), 32'd1);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check_result("hold_start_ignored", 32'd5, 32'h4d, 32'd64);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
        check_output("ackstart_valid", 32'(bus.class_valid), 32'd0);
        check_output("ackstart_busy",  32'(bus.busy),        32'd1);
        for (int i = 0; i < NUM_CLASSES; i++) begin
            apply_stimulus(1'b0, 1'b1, 8'(50 - 2 * i), 1'b0);
        end
        check_result("ackstart", 32'd0, 32'h32, 32'd2);
        check_output("sticky_seqerr", 32'(bus.seq_err), 32'd1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a frame
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b1, 8'd40, 1'b0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_output("async_busy",   32'(bus.busy),         32'd0);
        check_output("async_seqerr", 32'(bus.seq_err),      32'd0);
        check_output("async_score",  32'(bus.class_score),  32'd0);
        check_output("async_margin", 32'(bus.class_margin), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        end
        check_output("async_no_result", 32'(bus.class_valid), 32'd0);
        check_output("async_idle_busy", 32'(bus.busy),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
